// File: rtl/btn_if.sv
// btn_if: raw button levels in, debounced levels and press strobes out
interface btn_if #(
    parameter int NB_BTN = 3
);
    logic [NB_BTN-1:0] btn;
    logic [NB_BTN-1:0] level;
    logic [NB_BTN-1:0] pulse;
    modport master (output btn, input level, input pulse);
    modport slave (input btn, output level, output pulse);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize and debounce NB_BTN raw buttons into clean levels and one-shot press pulses
module btn_conditioner #(
    parameter int NB_BTN = 3,
    parameter int NB_CNT = 20,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    btn_if.slave bus
);
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << NB_CNT) - 1) begin : g_bad_cycles
        $error("btn_conditioner: DEBOUNCE_CYCLES must lie in 1 .. 2**NB_CNT-1");
    end
    localparam logic [NB_CNT-1:0] LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_CNT-1:0] ONE = NB_CNT'(1);
    typedef enum logic [1:0] {LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW} state_t;
    state_t [NB_BTN-1:0] state;
    logic [NB_BTN-1:0][NB_CNT-1:0] cnt;
    logic [NB_BTN-1:0] sync_q;
    logic [NB_BTN-1:0] s;
    logic [NB_BTN-1:0] level;
    logic [NB_BTN-1:0] pulse;
    // two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
            s <= '0;
        end else begin
            sync_q <= bus.btn;
            s <= sync_q;
        end
    end
    // per-channel debounce FSM: a level change is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NB_BTN; i++) begin
            if (i_reset) begin
                state[i] <= LOW_STABLE;
                cnt[i] <= '0;
                level[i] <= 1'b0;
                pulse[i] <= 1'b0;
            end else begin
                pulse[i] <= 1'b0;
                case (state[i])
                    LOW_STABLE:
                        if (!s[i]) begin
                            cnt[i] <= '0;
                        end else if (LAST == '0) begin
                            state[i] <= HIGH_STABLE;
                            cnt[i] <= '0;
                            level[i] <= 1'b1;
                            pulse[i] <= 1'b1;
                        end else begin
                            state[i] <= LOW_TO_HIGH;
                            cnt[i] <= ONE;
                        end
                    LOW_TO_HIGH:
                        if (!s[i]) begin
                            state[i] <= LOW_STABLE;
                            cnt[i] <= '0;
                        end else if (cnt[i] == LAST) begin
                            state[i] <= HIGH_STABLE;
                            cnt[i] <= '0;
                            level[i] <= 1'b1;
                            pulse[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + ONE;
                        end
                    HIGH_STABLE:
                        if (s[i]) begin
                            cnt[i] <= '0;
                        end else if (LAST == '0) begin
                            state[i] <= LOW_STABLE;
                            cnt[i] <= '0;
                            level[i] <= 1'b0;
                        end else begin
                            state[i] <= HIGH_TO_LOW;
                            cnt[i] <= ONE;
                        end
                    HIGH_TO_LOW:
                        if (s[i]) begin
                            state[i] <= HIGH_STABLE;
                            cnt[i] <= '0;
                        end else if (cnt[i] == LAST) begin
                            state[i] <= LOW_STABLE;
                            cnt[i] <= '0;
                            level[i] <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + ONE;
                        end
                endcase
            end
        end
    end
    assign bus.level = level;
    assign bus.pulse = pulse;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and randomized checks of btn_conditioner against a run-length reference model
module tb_btn_conditioner;
    localparam int NB = 3;
    localparam int D = 4;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    btn_if #(.NB_BTN(NB)) bus ();
    btn_conditioner #(.NB_BTN(NB), .NB_CNT(8), .DEBOUNCE_CYCLES(D)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .bus(bus)
    );
    always #5 i_clk = ~i_clk;
    int n_checks = 0;
    int n_fail = 0;
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_pulse;
    int m_run [NB];
    int max_cnt;
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    // one clock edge: drive inputs, advance the reference model, settle
    task automatic tick(input logic [NB-1:0] b, input logic r);
        bus.btn = b;
        i_reset = r;
        @(posedge i_clk);
        if (r) begin
            m_s1 = '0;
            m_s2 = '0;
            m_lvl = '0;
            m_pulse = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                m_pulse[i] = 1'b0;
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = m_s2[i];
                        m_pulse[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        #1;
        for (int i = 0; i < NB; i++) if (int'(dut.cnt[i]) > max_cnt) max_cnt = int'(dut.cnt[i]);
    endtask
    task automatic test_reset();
        tick('1, 1'b1);
        tick('1, 1'b1);
        n_checks++;
        if (bus.level !== '0) begin n_fail++; $display("FAIL reset_level: got %b want 000", bus.level); end
        n_checks++;
        if (bus.pulse !== '0) begin n_fail++; $display("FAIL reset_pulse: got %b want 000", bus.pulse); end
    endtask
    task automatic test_press();
        tick('0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            tick(3'b001, 1'b0);
            n_checks++;
            if (bus.pulse !== (k == 5 ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL press_pulse edge %0d: got %b want %b", k, bus.pulse, (k == 5 ? 3'b001 : 3'b000));
            end
            n_checks++;
            if (bus.level !== (k >= 5 ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL press_level edge %0d: got %b want %b", k, bus.level, (k >= 5 ? 3'b001 : 3'b000));
            end
        end
    endtask
    task automatic test_release();
        for (int k = 0; k < 8; k++) begin
            tick(3'b000, 1'b0);
            n_checks++;
            if (bus.level !== (k < 5 ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL release_level edge %0d: got %b want %b", k, bus.level, (k < 5 ? 3'b001 : 3'b000));
            end
            n_checks++;
            if (bus.pulse !== 3'b000) begin n_fail++; $display("FAIL release_pulse edge %0d: got %b want 000", k, bus.pulse); end
        end
    endtask
    task automatic test_bounce();
        logic [4:0] seq = 5'b01101;
        int pulses = 0;
        tick('0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            tick(k < 5 ? {1'b0, seq[k], 1'b0} : 3'b010, 1'b0);
            pulses += int'(bus.pulse[1]);
            n_checks++;
            if (bus.pulse !== (k == 10 ? 3'b010 : 3'b000)) begin
                n_fail++; $display("FAIL bounce_pulse edge %0d: got %b want %b", k, bus.pulse, (k == 10 ? 3'b010 : 3'b000));
            end
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL bounce_count: got %0d pulses want 1", pulses); end
    endtask
    task automatic test_all_channels();
        tick('0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick(3'b111, 1'b0);
            n_checks++;
            if (bus.pulse !== (k == 5 ? 3'b111 : 3'b000)) begin
                n_fail++; $display("FAIL all_pulse edge %0d: got %b want %b", k, bus.pulse, (k == 5 ? 3'b111 : 3'b000));
            end
        end
    endtask
    task automatic test_reset_mid();
        tick('0, 1'b1);
        for (int k = 0; k < 13; k++) begin
            tick(3'b001, k == 3);
            n_checks++;
            if (bus.pulse !== (k == 9 ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL reset_mid_pulse edge %0d: got %b want %b", k, bus.pulse, (k == 9 ? 3'b001 : 3'b000));
            end
            n_checks++;
            if (bus.level !== (k >= 9 ? 3'b001 : 3'b000)) begin
                n_fail++; $display("FAIL reset_mid_level edge %0d: got %b want %b", k, bus.level, (k >= 9 ? 3'b001 : 3'b000));
            end
        end
    endtask
    task automatic test_hold();
        int pulses = 0;
        tick('0, 1'b1);
        max_cnt = 0;
        for (int k = 0; k < 110; k++) begin
            tick(3'b001, 1'b0);
            pulses += int'(bus.pulse[0]);
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL hold_count: got %0d pulses want 1", pulses); end
        n_checks++;
        if (max_cnt > D - 1) begin n_fail++; $display("FAIL hold_counter_max: got %0d want <= %0d", max_cnt, D - 1); end
        n_checks++;
        if (bus.level !== 3'b001) begin n_fail++; $display("FAIL hold_level: got %b want 001", bus.level); end
    endtask
    task automatic test_random();
        logic [NB-1:0] b = '0;
        logic r;
        tick('0, 1'b1);
        max_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
            r = ($urandom_range(0, 299) == 0);
            tick(b, r);
            n_checks++;
            if (bus.level !== m_lvl) begin n_fail++; $display("FAIL random_level cycle %0d: got %b want %b", k, bus.level, m_lvl); end
            n_checks++;
            if (bus.pulse !== m_pulse) begin n_fail++; $display("FAIL random_pulse cycle %0d: got %b want %b", k, bus.pulse, m_pulse); end
        end
        n_checks++;
        if (max_cnt > D - 1) begin n_fail++; $display("FAIL random_counter_max: got %0d want <= %0d", max_cnt, D - 1); end
    endtask
    initial begin
        bus.btn = '0;
        max_cnt = 0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_all_channels();
        test_reset_mid();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
